// File: rtl/ttt_move_engine.sv
// ttt_move_engine: N x N tic-tac-toe opponent.
//
// A start request snapshots the board and mode. The engine then scans the
// 2N+2 lines, one per clock: rows, columns, the main diagonal and the
// anti-diagonal. On each line it records the first winning square and the
// first blocking square it finds. A final PICK cycle chooses the move by
// priority: win > block > center > corner > first empty. The result is held
// until the next PICK or until reset.
//
// Ports:
//   clk, reset  clock; asynchronous active-high reset
//   start       move request, sampled only while idle
//   board       2 bits per cell, cell k (1-based, row-major) at [2k-1:2k-2]
//               00 empty, 01 human, 10 computer, 11 illegal
//   mode        00/11 full strategy, 01 easy (no win/block), 10 first empty
//   busy        scan or pick in progress
//   done        one-cycle pulse when the result registers update
//   computer    1 when comppos holds a legal move
//   comppos     chosen cell, 1-based; 0 = no move
//   reason      0 none, 1 win, 2 block, 3 center, 4 corner, 5 first empty
//   board_full  snapshot had no empty cell
//   bad_board   snapshot contained an illegal (11) cell
module ttt_move_engine #(
  parameter int N     = 3,
  parameter int POS_W = $clog2(N*N+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*N*N-1:0]   board,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic               done,
  output logic               computer,
  output logic [POS_W-1:0]   comppos,
  output logic [2:0]         reason,
  output logic               board_full,
  output logic               bad_board
);

  localparam int CELLS  = N*N;
  localparam int LINES  = 2*N + 2;
  localparam int LW     = $clog2(LINES);
  localparam int CENTER = (N*N + 1) / 2;
  localparam int CRN1   = 1;
  localparam int CRN2   = N;
  localparam int CRN3   = N*N - N + 1;
  localparam int CRN4   = N*N;
  localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);

  localparam logic [2:0] R_NONE   = 3'd0;
  localparam logic [2:0] R_WIN    = 3'd1;
  localparam logic [2:0] R_BLOCK  = 3'd2;
  localparam logic [2:0] R_CENTER = 3'd3;
  localparam logic [2:0] R_CORNER = 3'd4;
  localparam logic [2:0] R_FIRST  = 3'd5;

  typedef enum logic [1:0] {IDLE, SCAN, PICK} state_t;

  state_t             state;
  logic [2*N*N-1:0]   snap;
  logic [1:0]         snap_mode;
  logic [LW-1:0]      line;
  logic               win_valid, blk_valid;
  logic [POS_W-1:0]   win_pos, blk_pos;

  logic [POS_W-1:0]   row_i, col_i, idx_i;
  logic [1:0]         cell_i;
  logic [POS_W-1:0]   cnt_c, cnt_h, cnt_e;
  logic [POS_W-1:0]   line_empty;
  logic [POS_W-1:0]   first_empty, corner_pos;
  logic               any_empty, any_bad, corner_found, center_ok;

  // Per-line tally for the line selected by the counter. Every line lists
  // its cells in ascending index order, so walking i downwards leaves the
  // lowest-index empty cell in line_empty.
  always_comb begin
    cnt_c      = '0;
    cnt_h      = '0;
    cnt_e      = '0;
    line_empty = '0;
    row_i      = '0;
    col_i      = '0;
    idx_i      = '0;
    cell_i     = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (line < LW'(N)) begin
        row_i = POS_W'(line);
        col_i = POS_W'(i);
      end else if (line < LW'(2*N)) begin
        row_i = POS_W'(i);
        col_i = POS_W'(line) - POS_W'(N);
      end else if (line == LW'(2*N)) begin
        row_i = POS_W'(i);
        col_i = POS_W'(i);
      end else begin
        row_i = POS_W'(i);
        col_i = POS_W'(N-1-i);
      end
      idx_i  = row_i * POS_W'(N) + col_i;
      cell_i = snap[2*idx_i +: 2];
      case (cell_i)
        2'b00: begin
          cnt_e      = cnt_e + POS_W'(1);
          line_empty = idx_i + POS_W'(1);
        end
        2'b01:   cnt_h = cnt_h + POS_W'(1);
        2'b10:   cnt_c = cnt_c + POS_W'(1);
        default: ;
      endcase
    end
  end

  // Whole-snapshot facts used in PICK: the lowest empty cell, any illegal
  // cell, and the lowest empty corner (checked high-to-low so lowest wins).
  always_comb begin
    first_empty  = '0;
    any_empty    = 1'b0;
    any_bad      = 1'b0;
    for (int k = CELLS-1; k >= 0; k--) begin
      if (snap[2*k +: 2] == 2'b00) begin
        first_empty = POS_W'(k + 1);
        any_empty   = 1'b1;
      end
      if (snap[2*k +: 2] == 2'b11) any_bad = 1'b1;
    end
    corner_found = 1'b0;
    corner_pos   = '0;
    if (snap[2*CRN4-2 +: 2] == 2'b00) begin corner_found = 1'b1; corner_pos = POS_W'(CRN4); end
    if (snap[2*CRN3-2 +: 2] == 2'b00) begin corner_found = 1'b1; corner_pos = POS_W'(CRN3); end
    if (snap[2*CRN2-2 +: 2] == 2'b00) begin corner_found = 1'b1; corner_pos = POS_W'(CRN2); end
    if (snap[2*CRN1-2 +: 2] == 2'b00) begin corner_found = 1'b1; corner_pos = POS_W'(CRN1); end
    center_ok = (N % 2 == 1) && (snap[2*CENTER-2 +: 2] == 2'b00);
  end

  // Control FSM. Result registers change only in PICK, so they hold across
  // a new request until that request completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      snap       <= '0;
      snap_mode  <= '0;
      line       <= '0;
      win_valid  <= 1'b0;
      win_pos    <= '0;
      blk_valid  <= 1'b0;
      blk_pos    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      computer   <= 1'b0;
      comppos    <= '0;
      reason     <= R_NONE;
      board_full <= 1'b0;
      bad_board  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap      <= board;
            snap_mode <= mode;
            line      <= '0;
            win_valid <= 1'b0;
            win_pos   <= '0;
            blk_valid <= 1'b0;
            blk_pos   <= '0;
            busy      <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (!win_valid && cnt_c == POS_W'(N-1) && cnt_e == POS_W'(1)) begin
            win_valid <= 1'b1;
            win_pos   <= line_empty;
          end
          if (!blk_valid && cnt_h == POS_W'(N-1) && cnt_e == POS_W'(1)) begin
            blk_valid <= 1'b1;
            blk_pos   <= line_empty;
          end
          if (line == LAST_LINE) state <= PICK;
          else                   line  <= line + LW'(1);
        end
        PICK: begin
          board_full <= !any_empty;
          bad_board  <= any_bad;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
          computer   <= any_empty;
          comppos    <= '0;
          reason     <= R_NONE;
          if (any_empty) begin
            if ((snap_mode == 2'b00 || snap_mode == 2'b11) && win_valid) begin
              comppos <= win_pos;
              reason  <= R_WIN;
            end else if ((snap_mode == 2'b00 || snap_mode == 2'b11) && blk_valid) begin
              comppos <= blk_pos;
              reason  <= R_BLOCK;
            end else if (snap_mode != 2'b10 && center_ok) begin
              comppos <= POS_W'(CENTER);
              reason  <= R_CENTER;
            end else if (snap_mode != 2'b10 && corner_found) begin
              comppos <= corner_pos;
              reason  <= R_CORNER;
            end else begin
              comppos <= first_empty;
              reason  <= R_FIRST;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_move_engine.sv
// tb_ttt_move_engine: directed bench for ttt_move_engine.
// A 3x3 instance runs a table of boards and several timing sequences; a 4x4
// instance checks latency and corner/win selection for even N.
// Boards are written as strings, one char per cell in cell order:
// '.' empty, 'H' human, 'C' computer, 'X' illegal.
module tb_ttt_move_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start3, start4;
  logic [17:0] board3;
  logic [31:0] board4;
  logic [1:0]  mode3, mode4;
  logic        busy3, done3, computer3, full3, bad3;
  logic        busy4, done4, computer4, full4, bad4;
  logic [3:0]  comppos3;
  logic [4:0]  comppos4;
  logic [2:0]  reason3, reason4;

  ttt_move_engine #(.N(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .board(board3), .mode(mode3),
    .busy(busy3), .done(done3), .computer(computer3), .comppos(comppos3),
    .reason(reason3), .board_full(full3), .bad_board(bad3)
  );

  ttt_move_engine #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .board(board4), .mode(mode4),
    .busy(busy4), .done(done4), .computer(computer4), .comppos(comppos4),
    .reason(reason4), .board_full(full4), .bad_board(bad4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    string      cells;
    logic [1:0] mode;
    logic       comp;
    logic [3:0] pos;
    logic [2:0] why;
    logic       full;
    logic       bad;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [49:0] mk(input string s);
    logic [49:0] b;
    b = '0;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "C":     b[2*i +: 2] = 2'b10;
        "H":     b[2*i +: 2] = 2'b01;
        "X":     b[2*i +: 2] = 2'b11;
        default: b[2*i +: 2] = 2'b00;
      endcase
    end
    return b;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Raise start before an edge and drop it 1 time unit after that edge (E0).
  task automatic apply_stimulus3(input string cells, input logic [1:0] m);
    logic [49:0] t;
    t = mk(cells);
    @(negedge clk);
    board3 = t[17:0];
    mode3  = m;
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
  endtask

  task automatic apply_stimulus4(input string cells, input logic [1:0] m);
    logic [49:0] t;
    t = mk(cells);
    @(negedge clk);
    board4 = t[31:0];
    mode4  = m;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
  endtask

  // Count edges after E0 until done is seen; -1 if the bound expires.
  task automatic wait_done3(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done3) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_done4(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done4) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int first_lat;
    logic [3:0] first_pos;
    logic [49:0] t;

    vecs[0]  = '{"win_row0",       "CC.HH....", 2'b00, 1'b1, 4'd3, 3'd1, 1'b0, 1'b0};
    vecs[1]  = '{"block_diag",     "HC..H....", 2'b00, 1'b1, 4'd9, 3'd2, 1'b0, 1'b0};
    vecs[2]  = '{"easy_corner",    "HC..H....", 2'b01, 1'b1, 4'd3, 3'd4, 1'b0, 1'b0};
    vecs[3]  = '{"win_over_block", "CC....HH.", 2'b00, 1'b1, 4'd3, 3'd1, 1'b0, 1'b0};
    vecs[4]  = '{"empty_center",   ".........", 2'b00, 1'b1, 4'd5, 3'd3, 1'b0, 1'b0};
    vecs[5]  = '{"empty_first",    ".........", 2'b10, 1'b1, 4'd1, 3'd5, 1'b0, 1'b0};
    vecs[6]  = '{"empty_mode11",   ".........", 2'b11, 1'b1, 4'd5, 3'd3, 1'b0, 1'b0};
    vecs[7]  = '{"col_win",        "HC.HC....", 2'b00, 1'b1, 4'd8, 3'd1, 1'b0, 1'b0};
    vecs[8]  = '{"anti_block",     "C.H.H....", 2'b00, 1'b1, 4'd7, 3'd2, 1'b0, 1'b0};
    vecs[9]  = '{"first_block",    "..HHH...H", 2'b00, 1'b1, 4'd6, 3'd2, 1'b0, 1'b0};
    vecs[10] = '{"full_draw",      "CHCCHHHCC", 2'b00, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0};
    vecs[11] = '{"full_mode10",    "CHCCHHHCC", 2'b10, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0};
    vecs[12] = '{"bad_first",      "HCHCHX...", 2'b10, 1'b1, 4'd7, 3'd5, 1'b0, 1'b1};
    vecs[13] = '{"bad_center",     "CCX......", 2'b00, 1'b1, 4'd5, 3'd3, 1'b0, 1'b1};
    vecs[14] = '{"easy_skip_win",  "HC.HC....", 2'b01, 1'b1, 4'd3, 3'd4, 1'b0, 1'b0};
    vecs[15] = '{"bad_full",       "CHCCXHHCC", 2'b00, 1'b0, 4'd0, 3'd0, 1'b1, 1'b1};

    reset  = 1'b1;
    start3 = 1'b0;
    start4 = 1'b0;
    board3 = '0;
    board4 = '0;
    mode3  = 2'b00;
    mode4  = 2'b00;
    #12;
    check_output("rst/busy",     busy3,     0);
    check_output("rst/done",     done3,     0);
    check_output("rst/computer", computer3, 0);
    check_output("rst/comppos",  comppos3,  0);
    check_output("rst/reason",   reason3,   0);
    check_output("rst/full",     full3,     0);
    check_output("rst/bad",      bad3,      0);
    check_output("rst4/busy",    busy4,     0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 16; v++) begin
      apply_stimulus3(vecs[v].cells, vecs[v].mode);
      check_output({vecs[v].name, "/busy"}, busy3, 1);
      wait_done3(lat);
      check_output({vecs[v].name, "/latency"},  lat,       9);
      check_output({vecs[v].name, "/computer"}, computer3, vecs[v].comp);
      check_output({vecs[v].name, "/comppos"},  comppos3,  vecs[v].pos);
      check_output({vecs[v].name, "/reason"},   reason3,   vecs[v].why);
      check_output({vecs[v].name, "/full"},     full3,     vecs[v].full);
      check_output({vecs[v].name, "/bad"},      bad3,      vecs[v].bad);
      check_output({vecs[v].name, "/busy_end"}, busy3,     0);
      @(posedge clk);
      #1;
      check_output({vecs[v].name, "/done_pulse"}, done3, 0);
    end

    // Start raised in the same cycle done is high is accepted.
    apply_stimulus3(".........", 2'b10);
    wait_done3(lat);
    check_output("b2b/first_pos", comppos3, 1);
    t = mk("CC.HH....");
    board3 = t[17:0];
    mode3  = 2'b00;
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    check_output("b2b/busy", busy3, 1);
    check_output("b2b/done", done3, 0);
    wait_done3(lat);
    check_output("b2b/latency", lat, 9);
    check_output("b2b/comppos", comppos3, 3);
    check_output("b2b/reason",  reason3,  1);

    // Results hold while idle and are not cleared by a new start.
    repeat (5) @(posedge clk);
    #1;
    check_output("hold/comppos", comppos3, 3);
    check_output("hold/reason",  reason3,  1);

    // Board changes during the scan are ignored.
    apply_stimulus3("HC..H....", 2'b00);
    check_output("hold/after_start", comppos3, 3);
    check_output("hold/comp_after_start", computer3, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    t = mk("CC.HH....");
    board3 = t[17:0];
    mode3  = 2'b10;
    wait_done3(lat);
    check_output("snap/latency", lat, 7);
    check_output("snap/comppos", comppos3, 9);
    check_output("snap/reason",  reason3,  2);

    // A start pulse while busy is dropped: exactly one done.
    apply_stimulus3("HC..H....", 2'b00);
    ndone     = 0;
    first_lat = -1;
    first_pos = '0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (done3) begin
        ndone++;
        if (first_lat < 0) begin
          first_lat = i;
          first_pos = comppos3;
        end
      end
      if (i == 3) begin
        t = mk(".........");
        board3 = t[17:0];
        start3 = 1'b1;
      end
      if (i == 4) start3 = 1'b0;
    end
    check_output("busy_start/done_count", ndone,     1);
    check_output("busy_start/latency",    first_lat, 9);
    check_output("busy_start/comppos",    first_pos, 9);

    // Reset during the fourth scan cycle aborts the request.
    apply_stimulus3(".........", 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("abort/busy",     busy3,     0);
    check_output("abort/done",     done3,     0);
    check_output("abort/computer", computer3, 0);
    check_output("abort/comppos",  comppos3,  0);
    check_output("abort/reason",   reason3,   0);
    check_output("abort/full",     full3,     0);
    check_output("abort/bad",      bad3,      0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done3) ndone++;
    end
    check_output("abort/no_done", ndone,    0);
    check_output("abort/comppos_after", comppos3, 0);

    // 4x4: no center, corner 1 on an empty board; row win otherwise.
    apply_stimulus4("................", 2'b00);
    check_output("n4_empty/busy", busy4, 1);
    wait_done4(lat);
    check_output("n4_empty/latency",  lat,       11);
    check_output("n4_empty/computer", computer4, 1);
    check_output("n4_empty/comppos",  comppos4,  1);
    check_output("n4_empty/reason",   reason4,   4);
    apply_stimulus4("CCC.HHH.........", 2'b00);
    wait_done4(lat);
    check_output("n4_win/latency", lat,      11);
    check_output("n4_win/comppos", comppos4, 4);
    check_output("n4_win/reason",  reason4,  1);
    apply_stimulus4(".CC.HHH.........", 2'b00);
    wait_done4(lat);
    check_output("n4_block/comppos", comppos4, 8);
    check_output("n4_block/reason",  reason4,  2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ttt_move_engine.md
Name: ttt_move_engine

Overview:
- Parametrised N×N tic-tac-toe move engine that replaces the fixed 3×3 combinational opponent logic.
- On a start request it snapshots the board and scans every row, column and both diagonals, one line per cycle.
- It then picks the computer's move by priority: win > block > center > corner > first empty.
- It sits between the board-state register file and the move-commit logic. Its result is registered and held until the next request.

Parameters:
- N, 3, board dimension; legal range 3..5; win length is N in a row.
- POS_W, $clog2(N*N+1), width of 1-based cell index; 0 means "no move".

Ports:
- clk  input  1  clock
- reset  input  1  reset
- start  input  1  request a move; sampled only when busy=0
- board  input  2*N*N  cell k (1-based, row-major, k=1 top-left) at bits [2k-1:2k-2]; 00 empty, 01 human, 10 computer, 11 illegal
- mode  input  2  00/11 full strategy; 01 easy (skip win/block); 10 first-empty only
- busy  output  1  engine is scanning or picking
- done  output  1  one-cycle pulse when result is valid
- computer  output  1  held; 1 = comppos is a legal move
- comppos  output  POS_W  held chosen cell, 1-based; 0 when no move
- reason  output  3  held; 0 none, 1 win, 2 block, 3 center, 4 corner, 5 first-empty
- board_full  output  1  held; no empty cell in snapshot
- bad_board  output  1  held; snapshot contained any 11 cell

Behaviour:
- Reset is asynchronous and active-high on clock clk. On reset: state=IDLE, busy=0, done=0, computer=0, comppos=0, reason=0, board_full=0, bad_board=0, all candidates cleared.
- States: IDLE, SCAN, PICK.
- IDLE:
  - start=1 at edge E0 latches board and mode into a snapshot, clears the candidates, sets line counter L=0, and goes to SCAN.
  - busy=1 from E0.
- SCAN: one line per edge, 2N+2 lines in fixed order:
  - rows 0..N-1, then columns 0..N-1, then the main diagonal (cells 1, N+2, ...), then the anti-diagonal (cells N, 2N-1, ...).
  - Per line, count computer cells (c), human cells (h) and empty cells (e). Record the lowest-index empty cell in the line.
  - Cells with value 11 count as occupied; they never satisfy c, h or e.
  - Win candidate: c=N-1 and e=1. Only the first line found (scan order) is kept.
  - Block candidate: h=N-1 and e=1. Only the first line found is kept.
  - After line 2N+1, go to PICK.
- PICK (edge E(2N+3)):
  - If board_full, or mode=10 with no empty cell: computer=0, comppos=0, reason=0.
  - Otherwise select the first applicable rule:
    1. win (modes 00/11 only)
    2. block (modes 00/11 only)
    3. center — only if N is odd, center cell (N*N+1)/2 is empty, and mode≠10
    4. lowest-index empty corner from 1, N, N*N-N+1, N*N — mode≠10
    5. lowest-index empty cell
  - On selection: computer=1, comppos=chosen cell, reason=rule code.
  - Also registers board_full and bad_board, sets done=1 for this cycle only, busy=0, and returns to IDLE.
- Latency: done is visible after exactly 2N+3 edges from the start-sampling edge (N=3: 9; N=4: 11).
- Start while busy=1 is ignored, with no queueing. Start in the same cycle done=1 is accepted, because state is IDLE after PICK.
- Board changes during SCAN have no effect (snapshot only).
- Outputs computer, comppos, reason, board_full and bad_board hold their values until the next PICK or reset. They are not cleared on a new start.
- Reset asserted mid-SCAN aborts the scan: no done pulse, outputs return to reset values.
- Cell index arithmetic uses POS_W bits, is computed from row/column counters, and has no wrap-around beyond N*N.

Test Plan:
- N=3, mode 00, computer at 1,2 and human at 4,5 → done 9 cycles after start, computer=1, comppos=3, reason=1.
- N=3, mode 00, human at 1,5 and computer at 2 → comppos=9, reason=2. Same board in mode 01 → comppos=3 (first empty corner), reason=4.
- N=3, computer at 1,2, human at 7,8, cell 3 and cell 9 empty → win beats block: comppos=3, reason=1.
- Empty board: N=3 mode 00 → comppos=5, reason=3. N=3 mode 10 → comppos=1, reason=5. N=4 mode 00 → comppos=1, reason=4, done 11 cycles after start.
- N=3 full board with no winner → done pulse, computer=0, comppos=0, board_full=1. Board with cell 6=11 → bad_board=1, cell 6 never chosen.
- Reset at the 4th SCAN cycle → busy=0, no done pulse, all outputs 0. Start pulse while busy → ignored, exactly one done pulse. Board changed mid-scan → result matches the snapshot.
